// File: rtl/tdr_echo_timer.sv
// Time-domain reflectometry echo timer: launches one pulse, timestamps up to two
// departures of echo_in from its pre-launch level, and classifies the termination.
module tdr_echo_timer #(
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned MAX_WAIT    = 63,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             echo_in,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       echo_count,
  output logic [CNT_W-1:0] delay1,
  output logic [CNT_W-1:0] delay2,
  output logic [1:0]       fault_type
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_LISTEN,
    S_REPORT
  } state_t;

  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             base_q, base_d;
  logic             flag_q, flag_d;
  logic [1:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] wd1_q, wd1_d;
  logic [CNT_W-1:0] wd2_q, wd2_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       ec_q, ec_d;
  logic [CNT_W-1:0] d1_q, d1_d;
  logic [CNT_W-1:0] d2_q, d2_d;
  logic [1:0]       ft_q, ft_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    flag_d  = flag_q;
    wcnt_d  = wcnt_q;
    wd1_d   = wd1_q;
    wd2_d   = wd2_q;
    ec_d    = ec_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    ft_d    = ft_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = echo_in;
          cnt_d   = '0;
          flag_d  = 1'b0;
          wcnt_d  = '0;
          wd1_d   = '0;
          wd2_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH, S_LISTEN: begin
        // Holding at MAX_CNT keeps a full-range MAX_WAIT from wrapping on the exit cycle.
        if (cnt_q != MAX_CNT) cnt_d = cnt_q + CNT_W'(1);
        if ((echo_in != base_q) && !flag_q) begin
          flag_d = 1'b1;
          if (wcnt_q != 2'd3) wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd0) wd1_d = cnt_q;
          if (wcnt_q == 2'd1) wd2_d = cnt_q;
        end else if ((echo_in == base_q) && flag_q) begin
          flag_d = 1'b0;
        end
        if (state_q == S_LAUNCH) begin
          if (cnt_q == PW_LAST) state_d = S_LISTEN;
        end else if (cnt_q == MAX_CNT) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
        ec_d    = wcnt_q;
        d1_d    = wd1_q;
        d2_d    = wd2_q;
        if (wcnt_q == 2'd0)      ft_d = 2'b00;
        else if (wcnt_q == 2'd1) ft_d = base_q ? 2'b10 : 2'b01;
        else                     ft_d = 2'b11;
      end
      default: state_d = S_IDLE;
    endcase

    pulse_d = (state_d == S_LAUNCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= 1'b0;
      flag_q  <= 1'b0;
      wcnt_q  <= '0;
      wd1_q   <= '0;
      wd2_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ec_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      ft_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      flag_q  <= flag_d;
      wcnt_q  <= wcnt_d;
      wd1_q   <= wd1_d;
      wd2_q   <= wd2_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ec_q    <= ec_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ft_q    <= ft_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign echo_count = ec_q;
  assign delay1     = d1_q;
  assign delay2     = d2_q;
  assign fault_type = ft_q;

endmodule

// File: tb/tb_tdr_echo_timer.sv
// Directed bench for tdr_echo_timer: a line model drives echo_in from pulse_out and
// a cycle index k (k = cnt inside the measurement window).
module tb_tdr_echo_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       echo_in = 1'b0;
  logic       pulse_out, busy, done;
  logic [1:0] echo_count, fault_type;
  logic [7:0] delay1, delay2;

  int n_cmp = 0;
  int n_err = 0;

  int mode = 0;
  int k = 0;
  logic pulse_prev = 1'b0;

  tdr_echo_timer #(.PULSE_WIDTH(4), .MAX_WAIT(63), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .echo_in(echo_in),
    .pulse_out(pulse_out), .busy(busy), .done(done),
    .echo_count(echo_count), .delay1(delay1), .delay2(delay2),
    .fault_type(fault_type)
  );

  always #5 clk = ~clk;

  // Line model: 0 matched, 1 open, 2 short, 3 multi (8,16), 4 echo at k=63,
  // 5 four short echoes, 6 echo held from k=60, 7 line idles high.
  always @(negedge clk) begin
    if (pulse_out && !pulse_prev) k = 0;
    else k = k + 1;
    pulse_prev = pulse_out;
    case (mode)
      1: echo_in = pulse_out;
      2: echo_in = ~pulse_out;
      3: echo_in = busy && ((k >= 8 && k <= 11) || (k >= 16 && k <= 19));
      4: echo_in = busy && (k == 63);
      5: echo_in = busy && (k == 2 || k == 5 || k == 9 || k == 20);
      6: echo_in = busy && (k >= 60);
      7: echo_in = 1'b1;
      default: echo_in = 1'b0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns #1 after the accept edge.
  task automatic start_meas();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accept edge until done; also counts pulse_out-high cycles.
  task automatic wait_done(output int lat, output int pw);
    lat = 0;
    pw = 0;
    if (pulse_out) pw++;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (pulse_out) pw++;
    end
  endtask

  typedef struct {
    int         mode;
    logic [1:0] ec;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] ft;
  } vec_t;

  vec_t vecs[8];
  int lat, pw;
  int rises[$];
  logic busy_prev;

  initial begin
    vecs[0] = '{0, 2'd0, 8'd0,  8'd0,  2'b00};
    vecs[1] = '{1, 2'd1, 8'd0,  8'd0,  2'b01};
    vecs[2] = '{2, 2'd1, 8'd0,  8'd0,  2'b10};
    vecs[3] = '{3, 2'd2, 8'd8,  8'd16, 2'b11};
    vecs[4] = '{4, 2'd1, 8'd63, 8'd0,  2'b01};
    vecs[5] = '{5, 2'd3, 8'd2,  8'd5,  2'b11};
    vecs[6] = '{6, 2'd1, 8'd60, 8'd0,  2'b01};
    vecs[7] = '{7, 2'd0, 8'd0,  8'd0,  2'b00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", int'(pulse_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(echo_count), 0);
    chk("rst_delay1", int'(delay1), 0);
    chk("rst_delay2", int'(delay2), 0);
    chk("rst_fault", int'(fault_type), 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      mode = vecs[v].mode;
      start_meas();
      chk($sformatf("v%0d_busy_after_accept", v), int'(busy), 1);
      wait_done(lat, pw);
      chk($sformatf("v%0d_latency", v), lat, 65);
      chk($sformatf("v%0d_pulse_width", v), pw, 4);
      chk($sformatf("v%0d_busy_at_done", v), int'(busy), 0);
      chk($sformatf("v%0d_count", v), int'(echo_count), int'(vecs[v].ec));
      chk($sformatf("v%0d_delay1", v), int'(delay1), int'(vecs[v].d1));
      chk($sformatf("v%0d_delay2", v), int'(delay2), int'(vecs[v].d2));
      chk($sformatf("v%0d_fault", v), int'(fault_type), int'(vecs[v].ft));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_one_cycle", v), int'(done), 0);
    end

    // Results from a multi run must survive a new start until the next report.
    mode = 3;
    start_meas();
    wait_done(lat, pw);
    chk("hold_setup_count", int'(echo_count), 2);
    mode = 0;
    start_meas();
    repeat (10) @(posedge clk);
    #1;
    chk("hold_count", int'(echo_count), 2);
    chk("hold_delay1", int'(delay1), 8);
    chk("hold_delay2", int'(delay2), 16);
    chk("hold_fault", int'(fault_type), 3);
    wait_done(lat, pw);
    chk("hold_new_count", int'(echo_count), 0);
    chk("hold_new_delay1", int'(delay1), 0);

    // Multi run to get nonzero results, then reset at cnt=10 of another multi run.
    mode = 3;
    start_meas();
    wait_done(lat, pw);
    start_meas();
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_pulse", int'(pulse_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_count", int'(echo_count), 0);
    chk("midrst_delay1", int'(delay1), 0);
    chk("midrst_delay2", int'(delay2), 0);
    chk("midrst_fault", int'(fault_type), 0);
    rst = 1'b0;
    start_meas();
    wait_done(lat, pw);
    chk("restart_latency", lat, 65);
    chk("restart_count", int'(echo_count), 2);
    chk("restart_delay1", int'(delay1), 8);
    chk("restart_delay2", int'(delay2), 16);
    chk("restart_fault", int'(fault_type), 3);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vs_start_busy", int'(busy), 0);
    chk("rst_vs_start_pulse", int'(pulse_out), 0);
    rst = 1'b0;
    start = 1'b0;

    // start held high: one measurement every 66 cycles, busy rises spaced evenly.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    busy_prev = 1'b0;
    for (int i = 0; i < 210; i++) begin
      @(posedge clk);
      #1;
      if (busy && !busy_prev) rises.push_back(i);
      busy_prev = busy;
    end
    start = 1'b0;
    chk("held_num_starts", rises.size(), 4);
    if (rises.size() >= 3) begin
      chk("held_period_1", rises[1] - rises[0], 66);
      chk("held_period_2", rises[2] - rises[1], 66);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
